// File: rtl/lib_voq_input_buffer.sv
// Per-input virtual output queue stage: M circular FIFOs feeding one allocator row.
// Optional LIB_VOQ_OCCUPANCY_EN adds o_occupancy (registered per-VOQ count).
module lib_voq_input_buffer #(
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned DW   = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [DW-1:0]    i_dest,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [0:M-1]     o_request,
  input  logic [0:M-1]     i_grant,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [DW-1:0]    o_dest,
`ifdef LIB_VOQ_OCCUPANCY_EN
  output logic [0:M-1][CW-1:0] o_occupancy,
`endif
  output logic             o_grant_err
);

  logic [WIDTH-1:0] r_mem    [M][DEPTH];
  logic [PW-1:0]    r_wr_ptr [M];
  logic [PW-1:0]    r_rd_ptr [M];
  logic [CW-1:0]    r_count  [M];

  logic          w_dest_ok;
  logic [DW-1:0] w_wr_idx;
  logic          w_push;
  logic          w_gnt_any;
  logic          w_gnt_multi;
  logic [DW-1:0] w_gnt_idx;
  logic          w_pop;
  logic          w_err;
  logic [M-1:0]  w_inc;
  logic [M-1:0]  w_dec;

  // Ready depends only on i_dest and registered counts; the grant never feeds it.
  always_comb begin
    w_dest_ok = (32'(i_dest) < M);
    w_wr_idx  = w_dest_ok ? i_dest : '0;
    o_ready   = w_dest_ok && (r_count[w_wr_idx] != CW'(DEPTH));
    w_push    = i_valid && o_ready;
  end

  // Lowest set grant bit is served; any extra bit is a protocol error.
  always_comb begin
    w_gnt_any   = 1'b0;
    w_gnt_multi = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned j = 0; j < M; j++) begin
      if (i_grant[j]) begin
        if (w_gnt_any) begin
          w_gnt_multi = 1'b1;
        end else begin
          w_gnt_any = 1'b1;
          w_gnt_idx = DW'(j);
        end
      end
    end
    w_pop = w_gnt_any && (r_count[w_gnt_idx] != '0);
    w_err = w_gnt_multi || (w_gnt_any && !w_pop);
  end

  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    o_request = '0;
    for (int unsigned j = 0; j < M; j++) begin
      w_inc[j]     = w_push && (w_wr_idx == DW'(j));
      w_dec[j]     = w_pop && (w_gnt_idx == DW'(j));
      o_request[j] = (r_count[j] != '0);
    end
  end

`ifdef LIB_VOQ_OCCUPANCY_EN
  always_comb begin
    o_occupancy = '0;
    for (int unsigned j = 0; j < M; j++) begin
      o_occupancy[j] = r_count[j];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx][r_wr_ptr[w_wr_idx]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < M; j++) begin
        r_wr_ptr[j] <= '0;
        r_rd_ptr[j] <= '0;
        r_count[j]  <= '0;
      end
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_dest      <= '0;
      o_grant_err <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < M; j++) begin
        if (w_inc[j]) begin
          r_wr_ptr[j] <= r_wr_ptr[j] + 1'b1;
        end
        if (w_dec[j]) begin
          r_rd_ptr[j] <= r_rd_ptr[j] + 1'b1;
        end
        if (w_inc[j] && !w_dec[j]) begin
          r_count[j] <= r_count[j] + 1'b1;
        end else if (!w_inc[j] && w_dec[j]) begin
          r_count[j] <= r_count[j] - 1'b1;
        end
      end
      o_valid     <= w_pop;
      o_grant_err <= w_err;
      if (w_pop) begin
        o_data <= r_mem[w_gnt_idx][r_rd_ptr[w_gnt_idx]];
        o_dest <= w_gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_lib_voq_input_buffer.sv
// Directed bench for lib_voq_input_buffer (M=4, DEPTH=4, WIDTH=32).
module tb_lib_voq_input_buffer;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_data;
  logic [1:0]  i_dest;
  logic        i_valid;
  logic        o_ready;
  logic [0:3]  o_request;
  logic [0:3]  i_grant;
  logic [31:0] o_data;
  logic        o_valid;
  logic [1:0]  o_dest;
  logic        o_grant_err;
`ifdef LIB_VOQ_OCCUPANCY_EN
  logic [0:3][2:0] o_occupancy;
`endif

  int errs;
  int checks;

  lib_voq_input_buffer #(.M(4), .DEPTH(4), .WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data      (i_data),
    .i_dest      (i_dest),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_request   (o_request),
    .i_grant     (i_grant),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_dest      (o_dest),
`ifdef LIB_VOQ_OCCUPANCY_EN
    .o_occupancy (o_occupancy),
`endif
    .o_grant_err (o_grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gnt/req fields: bit j = VOQ j
  typedef struct {
    logic        vld;
    logic [1:0]  dest;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        rdy;
    logic [3:0]  req;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  odst;
    logic        err;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic vld, logic [1:0] dest, logic [31:0] data, logic [3:0] gnt,
                              logic rdy, logic [3:0] req, logic ov, logic [31:0] od,
                              logic [1:0] odst, logic err);
    vec_t v;
    v.vld = vld; v.dest = dest; v.data = data; v.gnt = gnt;
    v.rdy = rdy; v.req = req; v.ov = ov; v.od = od; v.odst = odst; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] req_vec();
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = o_request[j];
    return r;
  endfunction

  task automatic set_grant(input logic [3:0] g);
    for (int j = 0; j < 4; j++) i_grant[j] = g[j];
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset_n = 1'b0;
    i_data = '0;
    i_dest = '0;
    i_valid = 1'b0;
    i_grant = '0;

    //             vld dest data   gnt     rdy req     ov od     odst err
    tbl[0]  = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);
    tbl[1]  = mk(1, 2, 32'hA5, 4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);
    tbl[2]  = mk(0, 0, 32'h0,  4'b0100, 1, 4'b0100, 0, 32'h0,  0, 0);
    tbl[3]  = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 1, 32'hA5, 2, 0);
    tbl[4]  = mk(1, 0, 32'h1,  4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);
    tbl[5]  = mk(1, 0, 32'h2,  4'b0000, 1, 4'b0001, 0, 32'h0,  0, 0);
    tbl[6]  = mk(1, 0, 32'h3,  4'b0000, 1, 4'b0001, 0, 32'h0,  0, 0);
    tbl[7]  = mk(1, 0, 32'h4,  4'b0000, 1, 4'b0001, 0, 32'h0,  0, 0);
    tbl[8]  = mk(1, 0, 32'h5,  4'b0000, 0, 4'b0001, 0, 32'h0,  0, 0);
    tbl[9]  = mk(0, 1, 32'h0,  4'b0000, 1, 4'b0001, 0, 32'h0,  0, 0);
    tbl[10] = mk(0, 0, 32'h0,  4'b0001, 0, 4'b0001, 0, 32'h0,  0, 0);
    tbl[11] = mk(0, 0, 32'h0,  4'b0001, 1, 4'b0001, 1, 32'h1,  0, 0);
    tbl[12] = mk(0, 0, 32'h0,  4'b0001, 1, 4'b0001, 1, 32'h2,  0, 0);
    tbl[13] = mk(0, 0, 32'h0,  4'b0001, 1, 4'b0001, 1, 32'h3,  0, 0);
    tbl[14] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 1, 32'h4,  0, 0);
    tbl[15] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);
    tbl[16] = mk(1, 0, 32'h10, 4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);
    tbl[17] = mk(1, 2, 32'h20, 4'b0000, 1, 4'b0001, 0, 32'h0,  0, 0);
    tbl[18] = mk(0, 0, 32'h0,  4'b0101, 1, 4'b0101, 0, 32'h0,  0, 0);
    tbl[19] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0100, 1, 32'h10, 0, 1);
    tbl[20] = mk(0, 0, 32'h0,  4'b1000, 1, 4'b0100, 0, 32'h0,  0, 0);
    tbl[21] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0100, 0, 32'h0,  0, 1);
    tbl[22] = mk(0, 0, 32'h0,  4'b0100, 1, 4'b0100, 0, 32'h0,  0, 0);
    tbl[23] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 1, 32'h20, 2, 0);
    tbl[24] = mk(0, 0, 32'h0,  4'b0000, 1, 4'b0000, 0, 32'h0,  0, 0);

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_request", 32'(req_vec()), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_grant_err), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_dest", 32'(o_dest), 32'd0);
`ifdef LIB_VOQ_OCCUPANCY_EN
    chk("rst_occ", 32'(o_occupancy), 32'd0);
`endif
    reset_n = 1'b1;

    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      i_valid = tbl[k].vld;
      i_dest  = tbl[k].dest;
      i_data  = tbl[k].data;
      set_grant(tbl[k].gnt);
      #1;
      chk($sformatf("v%0d_ready", k), 32'(o_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d_request", k), 32'(req_vec()), 32'(tbl[k].req));
      chk($sformatf("v%0d_valid", k), 32'(o_valid), 32'(tbl[k].ov));
      chk($sformatf("v%0d_err", k), 32'(o_grant_err), 32'(tbl[k].err));
      if (tbl[k].ov) begin
        chk($sformatf("v%0d_data", k), o_data, tbl[k].od);
        chk($sformatf("v%0d_dest", k), 32'(o_dest), 32'(tbl[k].odst));
      end
    end

    // Streaming through VOQ3 across pointer wrap: push every cycle, grant from cycle 1
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      i_valid = (c < 10);
      i_dest  = 2'd3;
      i_data  = 32'h300 + 32'(c);
      set_grant((c >= 1 && c <= 10) ? 4'b1000 : 4'b0000);
      #1;
      chk($sformatf("w%0d_ready", c), 32'(o_ready), 32'd1);
      chk($sformatf("w%0d_err", c), 32'(o_grant_err), 32'd0);
      if (c >= 1 && c <= 10) chk($sformatf("w%0d_request", c), 32'(req_vec()), 32'b1000);
      if (c == 12) chk("w12_request", 32'(req_vec()), 32'd0);
`ifdef LIB_VOQ_OCCUPANCY_EN
      if (c >= 1 && c <= 10) chk($sformatf("w%0d_occ", c), 32'(o_occupancy[3]), 32'd1);
`endif
      if (c >= 2 && c <= 11) begin
        chk($sformatf("w%0d_valid", c), 32'(o_valid), 32'd1);
        chk($sformatf("w%0d_data", c), o_data, 32'h300 + 32'(c - 2));
        chk($sformatf("w%0d_dest", c), 32'(o_dest), 32'd3);
      end else begin
        chk($sformatf("w%0d_valid", c), 32'(o_valid), 32'd0);
      end
    end

    // Mid-operation reset with a grant in the same cycle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_dest  = 2'(c);
      i_data  = 32'h40 + 32'(c);
      i_grant = '0;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_dest  = 2'd0;
    #1;
    chk("mr_request_before", 32'(req_vec()), 32'b0111);
    set_grant(4'b0001);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_request", 32'(req_vec()), 32'd0);
    chk("mr_err", 32'(o_grant_err), 32'd0);
`ifdef LIB_VOQ_OCCUPANCY_EN
    chk("mr_occ", 32'(o_occupancy), 32'd0);
`endif
    reset_n = 1'b1;
    i_grant = '0;
    @(negedge clk);
    #1;
    chk("mr_post_valid", 32'(o_valid), 32'd0);
    chk("mr_post_request", 32'(req_vec()), 32'd0);
    chk("mr_post_ready", 32'(o_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
